// File: rtl/seg7_scan_controller_if.sv
// Signal bundle between the MMIO output port and the 7-segment scan controller.
// The controller is the slave; the MMIO side (or a bench) is the master.
interface seg7_scan_controller_if;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  digitEnable;
  logic [3:0]  brightness;
  logic [7:0]  segment;
  logic [3:0]  digit;
  logic        frameStart;

  modport master (
    output data, dp, digitEnable, brightness,
    input  segment, digit, frameStart
  );

  modport slave (
    input  data, dp, digitEnable, brightness,
    output segment, digit, frameStart
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// 4-digit multiplexed 7-segment scan controller: per-frame snapshot, blanking, PWM dimming.
// Optional build macro SEG7_SCAN_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 3 always shown).
module seg7_scan_controller #(
  parameter int unsigned TICK_DIV    = 781,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                   clock,
  input  logic                   notReset,
  seg7_scan_controller_if.slave  bus
);

  localparam int unsigned     TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {BLANK, LIT, DARK} slot_state_e;

  logic [TW-1:0] tick_cnt, tick_cnt_d;
  logic [3:0]    phase, phase_d;
  logic [1:0]    index, index_d;
  logic          tick, frame_end;
  slot_state_e   slot_state;

  logic [15:0]   data_s;
  logic [3:0]    dp_s, en_s, brightness_s;
  logic          load_q;

  logic [7:0]    segment_d, segment_q;
  logic [3:0]    digit_d, digit_q;
  logic          frame_start_q;

  logic          in_blank;
  logic [3:0]    nibble;
  logic          suppress;
  logic          show;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  if (BLANK_TICKS == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (phase < 4'(BLANK_TICKS));
  end

  // State register: scan counters, snapshot and registered pin outputs.
  always_ff @(posedge clock) begin
    if (!notReset) begin
      tick_cnt      <= '0;
      phase         <= '0;
      index         <= '0;
      data_s        <= '0;
      dp_s          <= '0;
      en_s          <= '0;
      brightness_s  <= '0;
      load_q        <= 1'b0;
      segment_q     <= '1;
      digit_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      tick_cnt      <= tick_cnt_d;
      phase         <= phase_d;
      index         <= index_d;
      load_q        <= frame_end;
      frame_start_q <= load_q;
      segment_q     <= segment_d;
      digit_q       <= digit_d;
      if (frame_end) begin
        data_s       <= bus.data;
        dp_s         <= bus.dp;
        en_s         <= bus.digitEnable;
        brightness_s <= bus.brightness;
      end
    end
  end

  // Next-state logic and slot state decode.
  always_comb begin
    tick       = (tick_cnt == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
    phase_d    = tick ? phase + 4'd1 : phase;
    index_d    = (tick && phase == 4'hF) ? index + 2'd1 : index;
    frame_end  = tick && (phase == 4'hF) && (index == 2'd3);

    if (in_blank)                   slot_state = BLANK;
    else if (phase <= brightness_s) slot_state = LIT;
    else                            slot_state = DARK;
  end

  // Output decode; registered above so segment and digit switch on the same edge.
  always_comb begin
    case (index)
      2'd0:    nibble = data_s[15:12];
      2'd1:    nibble = data_s[11:8];
      2'd2:    nibble = data_s[7:4];
      default: nibble = data_s[3:0];
    endcase

    suppress = 1'b0;
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    case (index)
      2'd0:    suppress = (data_s[15:12] == 4'h0);
      2'd1:    suppress = (data_s[15:8]  == 8'h00);
      2'd2:    suppress = (data_s[15:4]  == 12'h000);
      default: suppress = 1'b0;
    endcase
`endif

    show = (slot_state == LIT) && en_s[index] && !suppress;

    segment_d = '1;
    digit_d   = '1;
    if (show) begin
      segment_d = ~{dp_s[index], hex_glyph(nibble)};
      digit_d   = ~(4'b0001 << index);
    end
  end

  assign bus.segment    = segment_q;
  assign bus.digit      = digit_q;
  assign bus.frameStart = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: directed scenarios plus random input changes,
// every cycle compared against a frame/tick arithmetic model of the display.
module tb_seg7_scan_controller;

  localparam int unsigned TD    = 4;
  localparam int unsigned BT    = 1;
  localparam int unsigned FRAME = 64 * TD;

  logic clock = 1'b0;
  logic notReset = 1'b0;

  seg7_scan_controller_if bus();

  seg7_scan_controller #(.TICK_DIV(TD), .BLANK_TICKS(BT)) dut (
    .clock    (clock),
    .notReset (notReset),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: clocks since reset release and the frame snapshot.
  int unsigned n = 0;
  logic [15:0] snap_data = '0;
  logic [3:0]  snap_dp = '0, snap_en = '0, snap_br = '0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic void model_out(input int unsigned cnt, output logic [7:0] s, output logic [3:0] d);
    int unsigned t, ph, idx;
    logic [15:0] shifted;
    logic [3:0] nib;
    logic lit;
    t   = cnt / TD;
    ph  = t % 16;
    idx = (t / 16) % 4;
    shifted = snap_data >> (4 * (3 - idx));
    nib = shifted[3:0];
    lit = (ph >= BT) && (ph <= int'(snap_br)) && snap_en[idx];
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    if (idx < 3 && shifted == 16'h0) lit = 1'b0;
`endif
    s = lit ? ~{snap_dp[idx], glyph_tab[nib]} : 8'hFF;
    d = lit ? ~(4'b0001 << idx) : 4'hF;
  endfunction

  task automatic run(input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      logic [7:0] es;
      logic [3:0] ed;
      logic       ef;
      if (!notReset) begin
        es = 8'hFF; ed = 4'hF; ef = 1'b0;
      end else begin
        model_out(n, es, ed);
        ef = (n >= FRAME) && (n % FRAME == 0);
      end
      @(posedge clock);
      if (!notReset) begin
        n = 0;
        snap_data = '0; snap_dp = '0; snap_en = '0; snap_br = '0;
      end else begin
        if ((n + 1) % FRAME == 0) begin
          snap_data = bus.data;
          snap_dp   = bus.dp;
          snap_en   = bus.digitEnable;
          snap_br   = bus.brightness;
        end
        n++;
      end
      #1;
      checks++;
      assert (bus.segment === es) else begin
        errors++;
        $error("FAIL segment n=%0d: got %h expected %h", n, bus.segment, es);
      end
      checks++;
      assert (bus.digit === ed) else begin
        errors++;
        $error("FAIL digit n=%0d: got %h expected %h", n, bus.digit, ed);
      end
      checks++;
      assert (bus.frameStart === ef) else begin
        errors++;
        $error("FAIL frameStart n=%0d: got %b expected %b", n, bus.frameStart, ef);
      end
    end
  endtask

  initial begin
    bus.data = '0; bus.dp = '0; bus.digitEnable = '0; bus.brightness = '0;
    run(2);

    // Release, run partway, then reset mid-frame for 3 clocks.
    notReset = 1'b1;
    bus.data = 16'h1234; bus.dp = 4'h0; bus.digitEnable = 4'hF; bus.brightness = 4'hF;
    run(100);
    notReset = 1'b0;
    run(3);
    notReset = 1'b1;

    // First frame dark, second shows 1 2 3 4.
    run(FRAME);
    run(FRAME);

    // Change data in the middle of slot 1: current frame keeps 2,3,4.
    run(16 * TD + 30);
    bus.data = 16'hABCD;
    run(FRAME - (16 * TD + 30));
    run(FRAME);

    // Dimming, including brightness below the blank window.
    bus.data = 16'h1234;
    bus.brightness = 4'd3;
    run(2 * FRAME);
    bus.brightness = 4'd0;
    run(2 * FRAME);

    // Partial enables with a dp on a disabled digit.
    bus.brightness = 4'hF; bus.digitEnable = 4'b0101; bus.dp = 4'b0010;
    run(2 * FRAME);

    // Leading-zero values (suppressed only when the macro is defined).
    bus.digitEnable = 4'hF; bus.dp = 4'hF; bus.data = 16'h0050;
    run(2 * FRAME);
    bus.data = 16'h0000;
    run(2 * FRAME);

    // Random input changes at arbitrary times.
    for (int i = 0; i < 14; i++) begin
      run($urandom_range(20, 300));
      bus.data        = 16'($urandom);
      bus.dp          = 4'($urandom);
      bus.digitEnable = 4'($urandom);
      bus.brightness  = 4'($urandom_range(0, 15));
      if (i == 9) begin
        notReset = 1'b0;
        run($urandom_range(1, 4));
        notReset = 1'b1;
      end
    end
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
